// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C write master.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ACK_A,
    REG,
    ACK_R,
    DATA,
    ACK_D,
    STOP,
    DONE
  } state_t;

  typedef logic [1:0] qphase_t;

  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_ACK   = 1'b0;
  localparam logic I2C_NACK  = 1'b1;

  localparam qphase_t Q0 = 2'd0;
  localparam qphase_t Q1 = 2'd1;
  localparam qphase_t Q2 = 2'd2;
  localparam qphase_t Q3 = 2'd3;

endpackage

// File: rtl/i2c_phase_gen.sv
// Quarter-period prescaler: qtick marks the last clk of each quarter,
// phase walks q0..q3 per bit slot; both held at zero while disabled.
module i2c_phase_gen
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    en,
  output logic    qtick,
  output qphase_t phase
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign qtick = en && (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      phase <= Q0;
    end else if (!en) begin
      cnt   <= '0;
      phase <= Q0;
    end else if (qtick) begin
      cnt   <= '0;
      phase <= phase + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_master_write.sv
// I2C write master: START, addr+W, reg, data with ACK checks, STOP.
// A NACK in any ACK slot skips straight to STOP.
module i2c_master_write
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic [6:0] slave_addr_i,
  input  logic [7:0] reg_addr_i,
  input  logic [7:0] wdata_i,
  input  logic       SDA_i,
  output logic       SCL_o,
  output logic       SDA_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       ack_err_o
);

  state_t     state, state_n;
  qphase_t    phase;
  logic       qtick;
  logic       en;
  logic       slot_end;
  logic       ack_sample;
  logic       is_byte;
  logic       is_ack;
  logic       last_bit;
  logic [7:0] shreg;
  logic [7:0] reg_q;
  logic [7:0] data_q;
  logic [2:0] bit_cnt;
  logic       ack_err;
  logic       scl_c;
  logic       sda_c;

  assign en = (state != IDLE) && (state != DONE);

  i2c_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .qtick (qtick),
    .phase (phase)
  );

  assign slot_end   = qtick && (phase == Q3);
  assign is_byte    = state inside {ADDR, REG, DATA};
  assign is_ack     = state inside {ACK_A, ACK_R, ACK_D};
  assign ack_sample = is_ack && qtick && (phase == Q2);
  assign last_bit   = slot_end && (bit_cnt == 3'd7);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start_i)  state_n = START;
      START: if (slot_end) state_n = ADDR;
      ADDR:  if (last_bit) state_n = ACK_A;
      ACK_A: if (slot_end) state_n = ack_err ? STOP : REG;
      REG:   if (last_bit) state_n = ACK_R;
      ACK_R: if (slot_end) state_n = ack_err ? STOP : DATA;
      DATA:  if (last_bit) state_n = ACK_D;
      ACK_D: if (slot_end) state_n = STOP;
      STOP:  if (slot_end) state_n = DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Bit counter wraps 7->0 on its own as each byte hands over to ACK.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      reg_q   <= '0;
      data_q  <= '0;
      bit_cnt <= '0;
      ack_err <= 1'b0;
    end else begin
      if (state == IDLE && start_i) begin
        shreg   <= {slave_addr_i, I2C_WRITE};
        reg_q   <= reg_addr_i;
        data_q  <= wdata_i;
        bit_cnt <= '0;
        ack_err <= 1'b0;
      end
      if (slot_end && is_byte) begin
        shreg   <= {shreg[6:0], 1'b0};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (slot_end && state == ACK_A) shreg <= reg_q;
      if (slot_end && state == ACK_R) shreg <= data_q;
      if (ack_sample && SDA_i == I2C_NACK) ack_err <= 1'b1;
    end
  end

  always_comb begin
    scl_c = 1'b1;
    sda_c = 1'b1;
    unique case (1'b1)
      (state == START): begin
        sda_c = (phase == Q0) || (phase == Q1);
        scl_c = (phase != Q3);
      end
      (state == STOP): begin
        sda_c = (phase == Q2) || (phase == Q3);
        scl_c = (phase != Q0);
      end
      is_byte: begin
        sda_c = shreg[7];
        scl_c = (phase == Q1) || (phase == Q2);
      end
      is_ack: begin
        sda_c = 1'b1;
        scl_c = (phase == Q1) || (phase == Q2);
      end
      default: begin
        scl_c = 1'b1;
        sda_c = 1'b1;
      end
    endcase
  end

  assign SCL_o     = scl_c;
  assign SDA_o     = sda_c;
  assign busy_o    = (state != IDLE);
  assign done_o    = (state == DONE);
  assign ack_err_o = ack_err;

endmodule

// File: tb/tb_i2c_master_write.sv
// Directed bench for the I2C write master: byte framing, NACK paths,
// ignored starts, mid-transfer reset and back-to-back at CLK_DIV=1.
module tb_i2c_master_write;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [6:0] addr;
  logic [7:0] rg;
  logic [7:0] dat;
  logic       sda_in;
  logic       scl, sda, busy, done, err;

  logic       start1;
  logic       sda1_in;
  logic       scl1, sda1, busy1, done1, err1;

  int total = 0;
  int bad   = 0;

  localparam int LAT_FULL   = 29 * 4 * 4;
  localparam int LAT_NACK_A = 11 * 4 * 4;
  localparam int GAP_FAST   = 29 * 4 * 1 + 2;

  always #5 clk = ~clk;

  i2c_master_write #(.CLK_DIV(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start),
    .slave_addr_i (addr),
    .reg_addr_i   (rg),
    .wdata_i      (dat),
    .SDA_i        (sda_in),
    .SCL_o        (scl),
    .SDA_o        (sda),
    .busy_o       (busy),
    .done_o       (done),
    .ack_err_o    (err)
  );

  i2c_master_write #(.CLK_DIV(1)) dut1 (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start1),
    .slave_addr_i (addr),
    .reg_addr_i   (rg),
    .wdata_i      (dat),
    .SDA_i        (sda1_in),
    .SCL_o        (scl1),
    .SDA_o        (sda1),
    .busy_o       (busy1),
    .done_o       (done1),
    .ack_err_o    (err1)
  );

  // Drives one transaction on dut, acting as slave and bus monitor.
  task automatic run_txn(
    input  logic [6:0] a,
    input  logic [7:0] r,
    input  logic [7:0] d,
    input  logic [2:0] mask,
    input  int         poke_rise,
    input  bit         poke_done,
    output int         rises,
    output logic [7:0] b0,
    output logic [7:0] b1,
    output logic [7:0] b2,
    output int         starts,
    output int         stops,
    output int         lat,
    output logic       e
  );
    logic pscl, psda;
    bit   poked;
    rises = 0; b0 = '0; b1 = '0; b2 = '0;
    starts = 0; stops = 0; lat = -1; e = 1'bx;
    pscl = 1'b1; psda = 1'b1; poked = 0;
    sda_in = 1'b0;
    @(negedge clk);
    addr = a; rg = r; dat = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (k > 0) @(negedge clk);
      if (scl && !pscl) begin
        rises++;
        if (rises <= 8)                     b0 = {b0[6:0], sda};
        else if (rises >= 10 && rises <= 17) b1 = {b1[6:0], sda};
        else if (rises >= 19 && rises <= 26) b2 = {b2[6:0], sda};
      end
      if (scl && pscl && sda !== psda) begin
        if (!sda) starts++;
        else      stops++;
      end
      pscl = scl;
      psda = sda;
      sda_in = ((rises == 9)  && mask[0]) ||
               ((rises == 18) && mask[1]) ||
               ((rises == 27) && mask[2]);
      start = 1'b0;
      if (poke_rise != 0 && rises == poke_rise && !poked) begin
        start = 1'b1;
        addr = ~a; rg = ~r; dat = ~d;
        poked = 1;
      end
      if (done) begin
        lat = k;
        e = err;
        if (poke_done) start = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0; start1 = 1'b0;
    addr = '0; rg = '0; dat = '0;
    sda_in = 1'b0; sda1_in = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (scl !== 1'b1) begin bad++; $display("FAIL rst_scl got=%b want=1", scl); end
    total++; if (sda !== 1'b1) begin bad++; $display("FAIL rst_sda got=%b want=1", sda); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_ok();
    int rs, st, sp, lt;
    logic [7:0] b0, b1, b2;
    logic e;
    run_txn(7'h4B, 8'hAB, 8'h5A, 3'b000, 0, 0, rs, b0, b1, b2, st, sp, lt, e);
    // 27 data/ACK pulses plus the SCL rise inside STOP
    total++; if (rs !== 28) begin bad++; $display("FAIL ok_rises got=%0d want=28", rs); end
    total++; if (b0 !== 8'h96) begin bad++; $display("FAIL ok_addr got=%h want=96", b0); end
    total++; if (b1 !== 8'hAB) begin bad++; $display("FAIL ok_reg got=%h want=ab", b1); end
    total++; if (b2 !== 8'h5A) begin bad++; $display("FAIL ok_data got=%h want=5a", b2); end
    total++; if (st !== 1 || sp !== 1) begin bad++; $display("FAIL ok_startstop got=%0d/%0d want=1/1", st, sp); end
    total++; if (lt !== LAT_FULL) begin bad++; $display("FAIL ok_latency got=%0d want=%0d", lt, LAT_FULL); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL ok_ackerr got=%b want=0", e); end
  endtask

  task automatic test_patterns();
    int rs, st, sp, lt;
    logic [7:0] b0, b1, b2;
    logic e;
    run_txn(7'h7F, 8'h00, 8'hFF, 3'b000, 0, 0, rs, b0, b1, b2, st, sp, lt, e);
    total++; if (b0 !== 8'hFE) begin bad++; $display("FAIL pat_addr got=%h want=fe", b0); end
    total++; if (b1 !== 8'h00) begin bad++; $display("FAIL pat_reg got=%h want=00", b1); end
    total++; if (b2 !== 8'hFF) begin bad++; $display("FAIL pat_data got=%h want=ff", b2); end
    run_txn(7'h01, 8'h81, 8'h3C, 3'b000, 0, 0, rs, b0, b1, b2, st, sp, lt, e);
    total++; if (b0 !== 8'h02) begin bad++; $display("FAIL pat2_addr got=%h want=02", b0); end
    total++; if (b1 !== 8'h81 || b2 !== 8'h3C) begin bad++; $display("FAIL pat2_bytes got=%h %h want=81 3c", b1, b2); end
  endtask

  task automatic test_nack_addr();
    int rs, st, sp, lt;
    logic [7:0] b0, b1, b2;
    logic e;
    run_txn(7'h4B, 8'hAB, 8'h5A, 3'b001, 0, 0, rs, b0, b1, b2, st, sp, lt, e);
    // 8 address bits, the ACK pulse, then only the STOP rise
    total++; if (rs !== 10) begin bad++; $display("FAIL na_rises got=%0d want=10", rs); end
    total++; if (b0 !== 8'h96) begin bad++; $display("FAIL na_addr got=%h want=96", b0); end
    total++; if (e !== 1'b1) begin bad++; $display("FAIL na_ackerr got=%b want=1", e); end
    total++; if (sp !== 1) begin bad++; $display("FAIL na_stop got=%0d want=1", sp); end
    total++; if (lt !== LAT_NACK_A) begin bad++; $display("FAIL na_latency got=%0d want=%0d", lt, LAT_NACK_A); end
    @(negedge clk);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL na_errhold got=%b want=1", err); end
  endtask

  task automatic test_nack_data();
    int rs, st, sp, lt;
    logic [7:0] b0, b1, b2;
    logic e;
    run_txn(7'h4B, 8'hAB, 8'h5A, 3'b100, 0, 0, rs, b0, b1, b2, st, sp, lt, e);
    total++; if (rs !== 28) begin bad++; $display("FAIL nd_rises got=%0d want=28", rs); end
    total++; if (b2 !== 8'h5A) begin bad++; $display("FAIL nd_data got=%h want=5a", b2); end
    total++; if (e !== 1'b1) begin bad++; $display("FAIL nd_ackerr got=%b want=1", e); end
    total++; if (sp !== 1) begin bad++; $display("FAIL nd_stop got=%0d want=1", sp); end
    total++; if (lt !== LAT_FULL) begin bad++; $display("FAIL nd_latency got=%0d want=%0d", lt, LAT_FULL); end
  endtask

  task automatic test_ignored_start();
    int rs, st, sp, lt;
    logic [7:0] b0, b1, b2;
    logic e;
    run_txn(7'h4B, 8'hAB, 8'h5A, 3'b000, 12, 1, rs, b0, b1, b2, st, sp, lt, e);
    total++; if (b1 !== 8'hAB || b2 !== 8'h5A) begin bad++; $display("FAIL ign_bytes got=%h %h want=ab 5a", b1, b2); end
    total++; if (lt !== LAT_FULL) begin bad++; $display("FAIL ign_latency got=%0d want=%0d", lt, LAT_FULL); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_busydrop got=%b want=0", busy); end
    start = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0 || scl !== 1'b1 || sda !== 1'b1) begin
      bad++; $display("FAIL ign_idle got=busy%b scl%b sda%b want=busy0 scl1 sda1", busy, scl, sda);
    end
  endtask

  task automatic test_reset_mid();
    int rs, st, sp, lt, rises;
    logic [7:0] b0, b1, b2;
    logic e, pscl, hit;
    sda_in = 1'b0;
    @(negedge clk);
    addr = 7'h4B; rg = 8'hAB; dat = 8'h5A; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rises = 0; pscl = 1'b1; hit = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      if (k > 0) @(negedge clk);
      if (scl && !pscl) rises++;
      pscl = scl;
      if (rises == 21 && !scl) begin hit = 1'b1; break; end
    end
    total++; if (hit !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL rm_reach got=hit%b busy%b want=hit1 busy1", hit, busy); end
    reset = 1'b1;
    #1;
    total++; if (scl !== 1'b1 || sda !== 1'b1) begin bad++; $display("FAIL rm_bus got=scl%b sda%b want=scl1 sda1", scl, sda); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rm_flags got=busy%b done%b want=0 0", busy, done); end
    @(negedge clk);
    reset = 1'b0;
    run_txn(7'h4B, 8'hAB, 8'h5A, 3'b000, 0, 0, rs, b0, b1, b2, st, sp, lt, e);
    total++; if (b0 !== 8'h96 || b1 !== 8'hAB || b2 !== 8'h5A) begin
      bad++; $display("FAIL rm_rerun got=%h %h %h want=96 ab 5a", b0, b1, b2);
    end
    total++; if (lt !== LAT_FULL || e !== 1'b0) begin bad++; $display("FAIL rm_relat got=%0d err%b want=%0d err0", lt, e, LAT_FULL); end
  endtask

  task automatic test_back_to_back();
    int   nd, starts, stops, shape_bad, rises, rises_at[3], dt[3];
    logic pscl, psda, expect_stop;
    nd = 0; starts = 0; stops = 0; shape_bad = 0; rises = 0;
    pscl = 1'b1; psda = 1'b1; expect_stop = 1'b0;
    sda1_in = 1'b0;
    @(negedge clk);
    start1 = 1'b1;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (scl1 && !pscl) rises++;
      if (scl1 && pscl && sda1 !== psda) begin
        if (!sda1) begin
          if (expect_stop) shape_bad++;
          starts++; expect_stop = 1'b1;
        end else begin
          if (!expect_stop) shape_bad++;
          stops++; expect_stop = 1'b0;
        end
      end
      pscl = scl1;
      psda = sda1;
      if (done1) begin
        dt[nd] = k;
        rises_at[nd] = rises;
        rises = 0;
        nd++;
        if (nd == 3) break;
      end
    end
    start1 = 1'b0;
    total++; if (nd !== 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", nd); end
    if (nd == 3) begin
      // 116 slot clks, the DONE clk, then one IDLE clk to accept again
      total++; if (dt[1] - dt[0] !== GAP_FAST) begin bad++; $display("FAIL b2b_gap1 got=%0d want=%0d", dt[1] - dt[0], GAP_FAST); end
      total++; if (dt[2] - dt[1] !== GAP_FAST) begin bad++; $display("FAIL b2b_gap2 got=%0d want=%0d", dt[2] - dt[1], GAP_FAST); end
      total++; if (rises_at[1] !== 28) begin bad++; $display("FAIL b2b_rises got=%0d want=28", rises_at[1]); end
    end
    total++; if (shape_bad !== 0) begin bad++; $display("FAIL b2b_shape got=%0d want=0", shape_bad); end
    total++; if (starts !== 3 || stops !== 3) begin bad++; $display("FAIL b2b_startstop got=%0d/%0d want=3/3", starts, stops); end
    total++; if (err1 !== 1'b0) begin bad++; $display("FAIL b2b_ackerr got=%b want=0", err1); end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_ok();
    test_patterns();
    test_nack_addr();
    test_nack_data();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
